spike_fusion: RTL and testbench
===============================

// Module: spike_fusion
// PURPOSE
//  Parametrised fusion stage for the spike-detector bank: takes N_DET per-sample detector
//  flags (neo/ado/aso/ed and future detectors) and emits one fused spike event.
//  - Fires when at least vote_k enabled detectors agree within a WIN-sample coincidence window.
//  - After firing, enforces a refractory period and counts events.
//  - Sits directly after the detector instances, before segmentation/classification.
// PARAMETERS
//  N_DET   4   number of detector flag inputs
//  WIN     8   coincidence window in valid samples; a hit stays active for WIN samples, >=1
//  REFRAC  32  refractory length in valid samples after a fused event, >=1
//  CNT_W   16  width of the saturating event counter
//  TS_W    32  width of the sample timestamp (only with FUSION_TIMESTAMP_EN)
// PORTS
//  clk           in   1                    system clock, all logic on rising edge
//  rst           in   1                    synchronous, active-low reset
//  sample_valid  in   1                    qualifies det_in; all sample-domain counters advance only when 1
//  det_in        in   N_DET                per-detector spike flags for the current sample
//  det_mask      in   N_DET                1 = detector participates in voting
//  vote_k        in   $clog2(N_DET+1)      votes required; 0 or >N_DET = fusion disabled
//  spike_out     out  1                    one-clk pulse per fused event
//  spike_src     out  N_DET                active-detector vector at the triggering sample, held until the next event
//  busy          out  1                    1 while in REFRACTORY
//  event_count   out  CNT_W                saturating count of fused events
//  ts_out        out  TS_W                 sample index of the triggering sample (FUSION_TIMESTAMP_EN only)
// BEHAVIOUR
//  Reset (rst==0 at clk edge):
//   - All outputs 0; stretch counters 0; FSM=ARMED; refractory counter 0; sample counter 0.
//  Stretch counters (one per detector, range 0..WIN):
//   - On a valid sample with det_in[i]&det_mask[i]: load WIN.
//   - Else on a valid sample with cnt>0: decrement.
//   - det_mask[i]==0: counter forced to 0 on the next clk, regardless of sample_valid.
//  Active vector and votes:
//   - act[i] = det_in[i]&det_mask[i]&sample_valid | (cnt[i]!=0).
//   - votes = popcount(act), combinational.
//  FSM ARMED:
//   - Trigger when sample_valid && vote_k!=0 && vote_k<=N_DET && votes>=vote_k.
//   - On the trigger edge: spike_out=1 for exactly one clk (registered, latency 1 clk after the trigger sample);
//     spike_src<=act; event_count+=1, saturating at all-ones; all stretch counters cleared;
//     refractory counter<=REFRAC; go REFRACTORY.
//  FSM REFRACTORY:
//   - busy=1; det_in ignored; stretch counters held at 0.
//   - Each valid sample decrements the refractory counter.
//   - The valid sample that takes it 1->0 returns the FSM to ARMED on that edge.
//   - Exactly REFRAC valid samples are ignored; detection resumes on the following valid sample.
//  sample_valid==0:
//   - No counter moves; no trigger; spike_out still drops after its single clk.
//  Simultaneous events:
//   - New hit on the trigger sample is consumed by the event, not carried into the next window.
//   - Mask and vote_k are sampled every clk, so changes take effect on the next sample.
//  Event counter:
//   - At saturation it holds all-ones.
//   - spike_out and spike_src still update.
//  Reset mid-refractory or mid-window:
//   - Immediate return to reset state; no pulse is emitted.
// CONFIGURATION
//  FUSION_TIMESTAMP_EN defined:
//   - Free-running TS_W sample counter, +1 per valid sample, wraps to 0 after all-ones.
//   - ts_out<=counter value of the triggering sample, updated together with spike_src.
//   - ts_out resets to 0.
//  FUSION_TIMESTAMP_EN undefined:
//   - No sample counter and no ts_out port; all other behaviour identical.
// TESTING
//  1 reset: rst=0 two clks with det_in=4'hF -> all outputs 0, busy=0, event_count=0.
//  2 window: vote_k=2, mask=F, WIN=8. det[0] at sample 0, det[2] at sample 5 ->
//    spike_out pulse 1 clk after sample 5, spike_src=4'b0101, event_count=1.
//  3 window expiry: det[0] at sample 0, det[1] at sample 9 (WIN=8) -> no pulse.
//  4 refractory: after event, det_in=F on every valid sample -> busy=1 for 32 samples,
//    next pulse on sample 33 after the trigger; gaps in sample_valid do not shorten it.
//  5 mask/disable: mask=4'b0001, vote_k=2, det_in=F -> never fires.
//    vote_k=0 or 5 -> never fires; unmask -> fires next sample.
//  6 saturation/timestamp: CNT_W=2, four events -> event_count stays 3, spike_out still pulses.
//    With FUSION_TIMESTAMP_EN: trigger at valid sample 100 -> ts_out=100; also check TS_W wrap.

Source files
------------

// File: rtl/spike_fusion.sv
// spike_fusion: k-of-N coincidence fusion of per-sample detector flags.
// Each enabled detector hit is stretched over WIN valid samples. A fused event
// fires when at least vote_k stretched hits overlap. After an event the block
// ignores REFRAC valid samples and counts events in a saturating counter.
// Optional feature: define FUSION_TIMESTAMP_EN to add a free-running sample
// counter and the ts_out port carrying the index of the triggering sample.
module spike_fusion #(
   parameter int N_DET  = 4,
   parameter int WIN    = 8,
   parameter int REFRAC = 32,
   parameter int CNT_W  = 16
`ifdef FUSION_TIMESTAMP_EN
   ,
   parameter int TS_W   = 32
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_valid,
   input  logic [N_DET-1:0]           det_in,
   input  logic [N_DET-1:0]           det_mask,
   input  logic [$clog2(N_DET+1)-1:0] vote_k,
   output logic                       spike_out,
   output logic [N_DET-1:0]           spike_src,
   output logic                       busy,
   output logic [CNT_W-1:0]           event_count
`ifdef FUSION_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]            ts_out
`endif
);

   localparam int VW  = $clog2(N_DET + 1);
   localparam int SCW = $clog2(WIN + 1);
   localparam int RCW = $clog2(REFRAC + 1);

   localparam logic StArmed  = 1'b0;
   localparam logic StRefrac = 1'b1;

   logic             state;
   logic [RCW-1:0]   refr_cnt;
   logic [SCW-1:0]   cnt [N_DET];
   logic [N_DET-1:0] act;
   logic [VW-1:0]    votes;
   logic             k_ok;
   logic             trigger;

   // Active vector: fresh enabled hits on this sample plus still-stretched hits.
   always_comb begin
      act   = det_in & det_mask & {N_DET{sample_valid}};
      votes = '0;
      for (int i = 0; i < N_DET; i++) begin
         if (cnt[i] != '0) act[i] = 1'b1;
      end
      for (int i = 0; i < N_DET; i++) begin
         votes = votes + VW'(act[i]);
      end
   end

   // Trigger decision; vote_k of 0 or above N_DET disables fusion.
   always_comb begin
      k_ok    = (vote_k != '0) && (vote_k <= VW'(N_DET));
      trigger = (state == StArmed) && sample_valid && k_ok && (votes >= vote_k);
   end

   assign busy = (state == StRefrac);

   // Per-detector stretch counters; masking clears even without a valid sample,
   // and the event consumes every pending hit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_DET; i++) begin
         if (!rst) begin
            cnt[i] <= '0;
         end else if (!det_mask[i] || (state == StRefrac) || trigger) begin
            cnt[i] <= '0;
         end else if (sample_valid) begin
            if (det_in[i]) begin
               cnt[i] <= SCW'(WIN);
            end else if (cnt[i] != '0) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   // Armed/refractory FSM with the registered event outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= StArmed;
         refr_cnt    <= '0;
         spike_out   <= 1'b0;
         spike_src   <= '0;
         event_count <= '0;
      end else begin
         spike_out <= trigger;
         case (state)
            StArmed: begin
               if (trigger) begin
                  state     <= StRefrac;
                  refr_cnt  <= RCW'(REFRAC);
                  spike_src <= act;
                  if (event_count != {CNT_W{1'b1}}) begin
                     event_count <= event_count + 1'b1;
                  end
               end
            end
            StRefrac: begin
               if (sample_valid) begin
                  refr_cnt <= refr_cnt - 1'b1;
                  // The sample taking the counter 1->0 is the last one ignored.
                  if (refr_cnt == RCW'(1)) state <= StArmed;
               end
            end
            default: state <= StArmed;
         endcase
      end
   end

`ifdef FUSION_TIMESTAMP_EN
   logic [TS_W-1:0] sample_cnt;

   // Free-running sample index; ts_out captures the index of the trigger sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sample_cnt <= '0;
         ts_out     <= '0;
      end else begin
         if (sample_valid) sample_cnt <= sample_cnt + 1'b1;
         if (trigger) ts_out <= sample_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_spike_fusion.sv
// Bench for spike_fusion: directed stimulus pushes expected fused events into a
// queue; an independent monitor pops one entry per spike_out pulse and compares
// the pulse edge, spike_src, event_count (and ts_out when the timestamp is built).
module tb_spike_fusion;

   localparam int N_DET  = 4;
   localparam int WIN    = 8;
   localparam int REFRAC = 32;
   localparam int CNT_W  = 2;
   localparam int TS_W   = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sample_valid = 1'b0;
   logic [3:0]       det_in = '0;
   logic [3:0]       det_mask = 4'hF;
   logic [2:0]       vote_k = 3'd2;
   logic             spike_out;
   logic [3:0]       spike_src;
   logic             busy;
   logic [CNT_W-1:0] event_count;
`ifdef FUSION_TIMESTAMP_EN
   logic [TS_W-1:0]  ts_out;
`endif

   spike_fusion #(
      .N_DET (N_DET),
      .WIN   (WIN),
      .REFRAC(REFRAC),
      .CNT_W (CNT_W)
`ifdef FUSION_TIMESTAMP_EN
      ,
      .TS_W  (TS_W)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_valid(sample_valid),
      .det_in      (det_in),
      .det_mask    (det_mask),
      .vote_k      (vote_k),
      .spike_out   (spike_out),
      .spike_src   (spike_src),
      .busy        (busy),
      .event_count (event_count)
`ifdef FUSION_TIMESTAMP_EN
      ,
      .ts_out      (ts_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      logic [3:0] src;
      logic [1:0] cnt;
      logic [7:0] ts;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc    = 0;
   int   sidx   = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse must match the oldest pending expected event.
   always @(negedge clk) begin
      if (spike_out) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse edge=%0d src=%b got pulse, required none", cyc,
                     spike_src);
         end else begin
            e = q.pop_front();
            checks += 3;
            if (cyc != e.edge_n) begin
               errors++;
               $display("FAIL pulse_edge got=%0d required=%0d", cyc, e.edge_n);
            end
            if (spike_src != e.src) begin
               errors++;
               $display("FAIL spike_src got=%b required=%b", spike_src, e.src);
            end
            if (event_count != e.cnt) begin
               errors++;
               $display("FAIL event_count got=%0d required=%0d", event_count, e.cnt);
            end
`ifdef FUSION_TIMESTAMP_EN
            checks++;
            if (ts_out != e.ts) begin
               errors++;
               $display("FAIL ts_out got=%0d required=%0d", ts_out, e.ts);
            end
`endif
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock with the given sample presented at the rising edge.
   task automatic step(input logic [3:0] d, input logic v);
      det_in       = d;
      sample_valid = v;
      @(posedge clk);
      #1;
      if (v && rst) sidx++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'h0, 1'b1);
   endtask

   // Call immediately before the step whose sample should trigger.
   task automatic expect_ev(input logic [3:0] src, input logic [1:0] c);
      exp_t x;
      x.edge_n = cyc + 1;
      x.src    = src;
      x.cnt    = c;
      x.ts     = sidx[7:0];
      q.push_back(x);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(4'hF, 1'b1);
      step(4'hF, 1'b1);
      rst  = 1'b1;
      sidx = 0;
   endtask

   logic [3:0] pats [4];

   initial begin
      pats[0] = 4'b0011;
      pats[1] = 4'b0110;
      pats[2] = 4'b1100;
      pats[3] = 4'b1001;
      #1;

      // Reset with all detectors firing: nothing may come out.
      do_reset();
      chk("rst_spike_out", spike_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_event_count", event_count, 0);
      chk("rst_spike_src", spike_src, 0);

      // Coincidence inside the window.
      step(4'b0001, 1'b1);
      idle(4);
      expect_ev(4'b0101, 2'd1);
      step(4'b0100, 1'b1);
      chk("win_busy", busy, 1);

      // Window expired: second hit 9 samples later.
      do_reset();
      step(4'b0001, 1'b1);
      idle(8);
      step(4'b0010, 1'b1);
      chk("expiry_busy", busy, 0);

      // Last sample still inside the window.
      do_reset();
      step(4'b0001, 1'b1);
      idle(7);
      expect_ev(4'b0011, 2'd1);
      step(4'b0010, 1'b1);

      // Masking clears a stretched hit even on an invalid cycle.
      do_reset();
      step(4'b0001, 1'b1);
      det_mask = 4'b1110;
      step(4'h0, 1'b0);
      det_mask = 4'hF;
      step(4'b0010, 1'b1);
      chk("maskclr_busy", busy, 0);

      // Refractory: exactly 32 valid samples ignored, gaps do not shorten it.
      do_reset();
      expect_ev(4'hF, 2'd1);
      step(4'hF, 1'b1);
      for (int i = 1; i <= REFRAC; i++) begin
         if (i % 5 == 0) begin
            step(4'hF, 1'b0);
            chk("refr_gap_busy", busy, 1);
         end
         step(4'hF, 1'b1);
         chk("refr_busy", busy, (i < REFRAC) ? 1 : 0);
      end
      expect_ev(4'hF, 2'd2);
      step(4'hF, 1'b1);
      idle(REFRAC);
      // Hits on the trigger sample were consumed; one lone hit cannot fire.
      step(4'b0010, 1'b1);
      chk("consumed_busy", busy, 0);

      // Mask and vote_k disable cases.
      do_reset();
      det_mask = 4'b0001;
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
      det_mask = 4'hF;
      vote_k   = 3'd0;
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
      vote_k = 3'd5;
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
      chk("disabled_count", event_count, 0);
      vote_k = 3'd2;
      step(4'hF, 1'b0);
      chk("novalid_busy", busy, 0);
      expect_ev(4'hF, 2'd1);
      step(4'hF, 1'b1);

      // Saturating counter with changing source vectors.
      do_reset();
      for (int n = 1; n <= 4; n++) begin
         expect_ev(pats[n-1], (n > 3) ? 2'd3 : 2'(n));
         step(pats[n-1], 1'b1);
         idle(REFRAC);
      end
      chk("sat_count", event_count, 3);

      // Reset in the middle of refractory returns to the idle state.
      do_reset();
      expect_ev(4'hF, 2'd1);
      step(4'hF, 1'b1);
      idle(5);
      chk("midrefr_busy", busy, 1);
      do_reset();
      chk("midrst_busy", busy, 0);
      chk("midrst_count", event_count, 0);
      chk("midrst_src", spike_src, 0);
      expect_ev(4'hF, 2'd1);
      step(4'hF, 1'b1);
      idle(REFRAC);

`ifdef FUSION_TIMESTAMP_EN
      // Timestamp at sample 100, then past the 8-bit wrap at sample 300.
      do_reset();
      idle(100);
      expect_ev(4'hF, 2'd1);
      step(4'hF, 1'b1);
      chk("ts_100", ts_out, 100);
      do_reset();
      idle(300);
      expect_ev(4'hF, 2'd1);
      step(4'hF, 1'b1);
      chk("ts_wrap", ts_out, 44);
`endif

      idle(4);
      chk("pending_events", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
